// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: default widths,
// the NOP/HALT words, the fetch FSM state encoding and a PC helper.
package if_stage_pkg;

   localparam int          IF_ADDR_W     = 32;
   localparam int          IF_DATA_W     = 32;
   localparam logic [31:0] NOP_WORD      = 32'h0000_0000;
   localparam logic [31:0] HALT_WORD_DEF = 32'hFC00_0000;

   typedef enum logic [1:0] {
      IF_IDLE = 2'd0,
      IF_RUN  = 2'd1,
      IF_HALT = 2'd2
   } if_state_e;

   // Force a target address onto a word boundary.
   function automatic logic [IF_ADDR_W-1:0] word_align(input logic [IF_ADDR_W-1:0] a);
      return {a[IF_ADDR_W-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/if_stage_if.sv
// Bundle of the fetch stage's control inputs, instruction-memory port,
// IF/ID outputs and debug state. Optional IF_PERF_CNT_EN adds counters.
interface if_stage_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   import if_stage_pkg::*;

   logic              load_pc;
   logic              stall;
   logic              redirect;
   logic [ADDR_W-1:0] redirect_pc;
   logic [ADDR_W-1:0] imem_addr;
   logic [DATA_W-1:0] imem_rdata;
   // ifid_valid qualifies ifid_*: when 0 the register holds a bubble
   // (NOP) and decode must ignore it; there is no back-pressure other
   // than stall, which freezes the register with its current contents.
   logic [DATA_W-1:0] ifid_instr;
   logic [ADDR_W-1:0] ifid_pc;
   logic [ADDR_W-1:0] ifid_pc4;
   logic              ifid_valid;
   logic              halted;
   if_state_e         dbg_state;
`ifdef IF_PERF_CNT_EN
   logic [31:0]       fetch_cnt;
   logic [31:0]       stall_cnt;
`endif

   modport master (
      input  load_pc, stall, redirect, redirect_pc, imem_rdata,
      output imem_addr, ifid_instr, ifid_pc, ifid_pc4, ifid_valid, halted, dbg_state
`ifdef IF_PERF_CNT_EN
      , output fetch_cnt, stall_cnt
`endif
   );

   modport slave (
      output load_pc, stall, redirect, redirect_pc, imem_rdata,
      input  imem_addr, ifid_instr, ifid_pc, ifid_pc4, ifid_valid, halted, dbg_state
`ifdef IF_PERF_CNT_EN
      , input fetch_cnt, stall_cnt
`endif
   );

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush inserts a bubble, hold freezes the
// contents, otherwise the fetched instruction is captured as valid.
module if_id_reg
   import if_stage_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              hold,
   input  logic [DATA_W-1:0] in_instr,
   input  logic [ADDR_W-1:0] in_pc,
   input  logic [ADDR_W-1:0] in_pc4,
   output logic [DATA_W-1:0] ifid_instr,
   output logic [ADDR_W-1:0] ifid_pc,
   output logic [ADDR_W-1:0] ifid_pc4,
   output logic              ifid_valid
);

   logic [DATA_W-1:0] instr_d, instr_q;
   logic [ADDR_W-1:0] pc_d, pc_q;
   logic [ADDR_W-1:0] pc4_d, pc4_q;
   logic              valid_d, valid_q;

   // Next contents: flush beats hold, hold beats load.
   always_comb begin
      instr_d = instr_q;
      pc_d    = pc_q;
      pc4_d   = pc4_q;
      valid_d = valid_q;
      if (flush) begin
         instr_d = DATA_W'(NOP_WORD);
         pc_d    = '0;
         pc4_d   = '0;
         valid_d = 1'b0;
      end else if (!hold) begin
         instr_d = in_instr;
         pc_d    = in_pc;
         pc4_d   = in_pc4;
         valid_d = 1'b1;
      end
   end

   // Register with asynchronous clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         instr_q <= '0;
         pc_q    <= '0;
         pc4_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         instr_q <= instr_d;
         pc_q    <= pc_d;
         pc4_q   <= pc4_d;
         valid_q <= valid_d;
      end
   end

   assign ifid_instr = instr_q;
   assign ifid_pc    = pc_q;
   assign ifid_pc4   = pc4_q;
   assign ifid_valid = valid_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives imem_addr, and feeds the
// IF/ID register. FSM IDLE -> RUN (load_pc) -> HALT (HALT word fetched).
// Build option IF_PERF_CNT_EN adds saturating fetch/stall counters.
module if_stage
   import if_stage_pkg::*;
#(
   parameter int                ADDR_W    = IF_ADDR_W,
   parameter int                DATA_W    = IF_DATA_W,
   parameter logic [ADDR_W-1:0] START_PC  = '0,
   parameter logic [DATA_W-1:0] HALT_WORD = HALT_WORD_DEF
) (
   input logic        clk,
   input logic        reset,
   if_stage_if.master bus
);

   if_state_e         state_d, state_q;
   logic [ADDR_W-1:0] pc_d, pc_q;
   logic [ADDR_W-1:0] pc4;
   logic              run, fetch_adv, halt_hit, stall_cyc, flush, hold;

   assign pc4 = pc_q + ADDR_W'(4);

   // Classify this cycle: load_pc > redirect > stall > normal advance.
   always_comb begin
      run       = (state_q == IF_RUN);
      fetch_adv = run && !bus.load_pc && !bus.redirect && !bus.stall;
      stall_cyc = run && !bus.load_pc && !bus.redirect && bus.stall;
      halt_hit  = fetch_adv && (bus.imem_rdata == HALT_WORD);
      flush     = bus.load_pc || !run || bus.redirect;
      hold      = stall_cyc;
   end

   // PC update; a fetched HALT word leaves the PC parked on itself.
   always_comb begin
      pc_d = pc_q;
      if (bus.load_pc)
         pc_d = START_PC;
      else if (run && bus.redirect)
         pc_d = word_align(bus.redirect_pc);
      else if (fetch_adv && !halt_hit)
         pc_d = pc4;
   end

   // FSM next state.
   always_comb begin
      state_d = state_q;
      if (bus.load_pc)
         state_d = IF_RUN;
      else if (halt_hit)
         state_d = IF_HALT;
   end

   // State and PC registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IF_IDLE;
         pc_q    <= START_PC;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end

   // FSM outputs and the combinational imem address.
   always_comb begin
      bus.halted    = (state_q == IF_HALT);
      bus.dbg_state = state_q;
      bus.imem_addr = pc_q;
   end

   logic [DATA_W-1:0] r_instr;
   logic [ADDR_W-1:0] r_pc, r_pc4;
   logic              r_valid;

   if_id_reg #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_if_id_reg (
      .clk        (clk),
      .reset      (reset),
      .flush      (flush),
      .hold       (hold),
      .in_instr   (bus.imem_rdata),
      .in_pc      (pc_q),
      .in_pc4     (pc4),
      .ifid_instr (r_instr),
      .ifid_pc    (r_pc),
      .ifid_pc4   (r_pc4),
      .ifid_valid (r_valid)
   );

   assign bus.ifid_instr = r_instr;
   assign bus.ifid_pc    = r_pc;
   assign bus.ifid_pc4   = r_pc4;
   assign bus.ifid_valid = r_valid;

`ifdef IF_PERF_CNT_EN
   logic [31:0] fetch_cnt_d, fetch_cnt_q;
   logic [31:0] stall_cnt_d, stall_cnt_q;

   // Saturating counters, cleared by load_pc.
   always_comb begin
      fetch_cnt_d = fetch_cnt_q;
      stall_cnt_d = stall_cnt_q;
      if (bus.load_pc) begin
         fetch_cnt_d = '0;
         stall_cnt_d = '0;
      end else begin
         if (fetch_adv && (fetch_cnt_q != 32'hFFFF_FFFF))
            fetch_cnt_d = fetch_cnt_q + 32'd1;
         if (stall_cyc && (stall_cnt_q != 32'hFFFF_FFFF))
            stall_cnt_d = stall_cnt_q + 32'd1;
      end
   end

   // Counter registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_cnt_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         fetch_cnt_q <= fetch_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign bus.fetch_cnt = fetch_cnt_q;
   assign bus.stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: reset/idle, sequential fetch, stall,
// redirect over stall, PC wrap, HALT and restart, async reset mid-run.
module tb_if_stage;
   import if_stage_pkg::*;

   logic clk;
   logic reset;
   int   checks   = 0;
   int   failures = 0;

   if_stage_if bus ();

   if_stage dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Instruction memory model: word index, except a HALT word at 0x10.
   always_comb begin
      if (bus.imem_addr == 32'h10)
         bus.imem_rdata = 32'hFC00_0000;
      else
         bus.imem_rdata = bus.imem_addr >> 2;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one clock edge and settle.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_ifid(input string tag, input logic [31:0] pc, input logic [31:0] instr);
      chk({tag, "_pc"},    bus.ifid_pc,    pc);
      chk({tag, "_pc4"},   bus.ifid_pc4,   pc + 32'd4);
      chk({tag, "_instr"}, bus.ifid_instr, instr);
      chk({tag, "_valid"}, 32'(bus.ifid_valid), 32'd1);
   endtask

   task automatic chk_bubble(input string tag);
      chk({tag, "_bvalid"}, 32'(bus.ifid_valid), 32'd0);
      chk({tag, "_binstr"}, bus.ifid_instr, 32'd0);
   endtask

   initial begin
      reset           = 1'b1;
      bus.load_pc     = 1'b0;
      bus.stall       = 1'b0;
      bus.redirect    = 1'b0;
      bus.redirect_pc = '0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;

      // 1: idle after reset, stall/redirect ignored, pc frozen
      chk("rst_addr",   bus.imem_addr, 32'h0);
      chk("rst_halted", 32'(bus.halted), 32'd0);
      chk("rst_state",  32'(bus.dbg_state), 32'(IF_IDLE));
      chk_bubble("rst");
      bus.redirect    = 1'b1;
      bus.redirect_pc = 32'h80;
      for (int i = 0; i < 5; i++) begin
         bus.stall = i[0];
         step();
         chk("idle_addr", bus.imem_addr, 32'h0);
         chk("idle_valid", 32'(bus.ifid_valid), 32'd0);
      end
      bus.redirect = 1'b0;
      bus.stall    = 1'b0;

      // 2: start fetch
      bus.load_pc = 1'b1;
      step();
      bus.load_pc = 1'b0;
      chk("ld_addr",  bus.imem_addr, 32'h0);
      chk("ld_state", 32'(bus.dbg_state), 32'(IF_RUN));
      chk_bubble("ld");
      step(); chk_ifid("f0", 32'h0, 32'h0);
      chk("f0_addr", bus.imem_addr, 32'h4);
      step(); chk_ifid("f4", 32'h4, 32'h1);
      step(); chk_ifid("f8", 32'h8, 32'h2);
      chk("f8_addr", bus.imem_addr, 32'hC);

      // 3: stall three cycles, then resume
      bus.stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk_ifid("stall", 32'h8, 32'h2);
         chk("stall_addr", bus.imem_addr, 32'hC);
      end
      bus.stall = 1'b0;
      step(); chk_ifid("fC", 32'hC, 32'h3);
      chk("fC_addr", bus.imem_addr, 32'h10);
`ifdef IF_PERF_CNT_EN
      chk("fetch_cnt", bus.fetch_cnt, 32'd4);
      chk("stall_cnt", bus.stall_cnt, 32'd3);
`endif

      // 4: redirect with stall (redirect wins, target aligned)
      bus.stall       = 1'b1;
      bus.redirect    = 1'b1;
      bus.redirect_pc = 32'h43;
      step();
      bus.stall    = 1'b0;
      bus.redirect = 1'b0;
      chk_bubble("redir");
      chk("redir_addr", bus.imem_addr, 32'h40);
      step(); chk_ifid("f40", 32'h40, 32'h10);
      chk("f40_addr", bus.imem_addr, 32'h44);

      // PC wrap at the top of the address space
      bus.redirect    = 1'b1;
      bus.redirect_pc = 32'hFFFF_FFFF;
      step();
      bus.redirect = 1'b0;
      chk("wrap_addr0", bus.imem_addr, 32'hFFFF_FFFC);
      step();
      chk("wrap_pc",    bus.ifid_pc,    32'hFFFF_FFFC);
      chk("wrap_pc4",   bus.ifid_pc4,   32'h0);
      chk("wrap_instr", bus.ifid_instr, 32'h3FFF_FFFF);
      chk("wrap_addr1", bus.imem_addr,  32'h0);

      // 5: run into the HALT word at 0x10
      step(); chk_ifid("h0", 32'h0, 32'h0);
      step(); chk_ifid("h4", 32'h4, 32'h1);
      step(); chk_ifid("h8", 32'h8, 32'h2);
      step(); chk_ifid("hC", 32'hC, 32'h3);
      step(); chk_ifid("halt", 32'h10, 32'hFC00_0000);
      chk("halt_halted", 32'(bus.halted), 32'd1);
      chk("halt_addr",   bus.imem_addr, 32'h10);
      bus.redirect    = 1'b1;
      bus.redirect_pc = 32'h80;
      step();
      bus.redirect = 1'b0;
      chk_bubble("halted");
      chk("halted_flag", 32'(bus.halted), 32'd1);
      chk("halted_addr", bus.imem_addr, 32'h10);
      bus.load_pc = 1'b1;
      step();
      bus.load_pc = 1'b0;
      chk("restart_addr",   bus.imem_addr, 32'h0);
      chk("restart_halted", 32'(bus.halted), 32'd0);
      chk_bubble("restart");
      step(); chk_ifid("r0", 32'h0, 32'h0);
      step(); chk_ifid("r4", 32'h4, 32'h1);

      // 6: asynchronous reset between edges
      #2;
      reset = 1'b1;
      #1;
      chk("arst_addr",   bus.imem_addr, 32'h0);
      chk("arst_pc",     bus.ifid_pc,   32'h0);
      chk("arst_pc4",    bus.ifid_pc4,  32'h0);
      chk("arst_halted", 32'(bus.halted), 32'd0);
      chk("arst_state",  32'(bus.dbg_state), 32'(IF_IDLE));
      chk_bubble("arst");
`ifdef IF_PERF_CNT_EN
      chk("arst_fetch_cnt", bus.fetch_cnt, 32'd0);
      chk("arst_stall_cnt", bus.stall_cnt, 32'd0);
`endif
      reset = 1'b0;
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
